// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter needs at least one bit even when a single digit covers the word.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/seq_adder_digit_add.sv
// Combinational DIGIT-bit ripple of full adders; exposes the carry into the
// MSB so the caller can derive two's-complement overflow.
module digit_add #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice per clock through a
// single shared digit_add, result held in DONE until the consumer takes it.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             V,
    output logic [1:0]       dbg_state
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready and is held by its source until then.
    state_t           state_q, state_d;
    logic             accept, step, last_digit;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIGIT-1:0] a_dig [NDIG];
    logic [DIGIT-1:0] b_dig [NDIG];
    logic [DIGIT-1:0] d_sum;
    logic             d_cout, d_cmsb;

    assign accept     = in_ready & in_valid;
    assign step       = (state_q == RUN);
    assign last_digit = (cnt_q == LAST);
    assign dbg_state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN:  if (last_digit) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is folded in at capture time: B is inverted and the carry
    // seeded to 1, so the RUN loop only ever adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            C_out   <= 1'b0;
            V       <= 1'b0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= SUB ? ~B : B;
            carry_q <= SUB | C_in;
            cnt_q   <= '0;
        end else if (step) begin
            carry_q <= d_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (last_digit) begin
                C_out <= d_cout;
                V     <= d_cout ^ d_cmsb;
            end
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        assign a_dig[g] = a_q[g*DIGIT +: DIGIT];
        assign b_dig[g] = b_q[g*DIGIT +: DIGIT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                S[g*DIGIT +: DIGIT] <= '0;
            else if (step && (cnt_q == CNT_W'(g)))
                S[g*DIGIT +: DIGIT] <= d_sum;
        end
    end

    digit_add #(.DIGIT(DIGIT)) u_digit_add (
        .a     (a_dig[cnt_q]),
        .b     (b_dig[cnt_q]),
        .cin   (carry_q),
        .sum   (d_sum),
        .cout  (d_cout),
        .c_msb (d_cmsb)
    );

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder (WIDTH=16, DIGIT=4) against a plain
// arithmetic reference model.
module tb_seq_adder;
    import seq_adder_pkg::*;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] A, B, S;
    logic             C_in, SUB;
    logic             out_valid, out_ready;
    logic             C_out, V;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seq_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C_in(C_in), .SUB(SUB), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .C_out(C_out), .V(V), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: returns {V, C_out, S} from integer arithmetic on WIDTH+1 bits.
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic cin, input logic sub);
        logic [WIDTH-1:0] bop;
        logic [WIDTH:0]   full;
        logic             v;
        bop  = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bop} + (sub ? 17'd1 : {16'd0, cin});
        v    = (a[WIDTH-1] == bop[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {v, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    // Drives one operand set from a negedge in IDLE; returns the result seen at
    // the first negedge with out_valid and the number of edges past acceptance.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub,
                          output logic [WIDTH+1:0] res, output int lat, output int acc_cyc);
        A = a; B = b; C_in = cin; SUB = sub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom);
        C_in = 1'($urandom); SUB = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = {V, C_out, S};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; C_in = 1'b0; SUB = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({S, C_out, V, out_valid} !== 19'd0) begin
            n_fail++; $display("FAIL reset_outputs got S=%h C=%b V=%b ov=%b want 0", S, C_out, V, out_valid);
        end
        n_checks++;
        if (dbg_state !== 2'(IDLE)) begin
            n_fail++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [WIDTH+1:0] res;
        logic [WIDTH+1:0] exp_res [3];
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic             vc [3];
        logic             vs [3];
        int lat, acc;
        va = '{16'hFFFF, 16'h7FFF, 16'h0005};
        vb = '{16'h0001, 16'h0001, 16'h0007};
        vc = '{1'b0, 1'b0, 1'b1};
        vs = '{1'b0, 1'b0, 1'b1};
        exp_res = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000}, {1'b0, 1'b0, 16'hFFFE}};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], vs[i], res, lat, acc);
            n_checks++;
            if (res !== exp_res[i]) begin
                n_fail++; $display("FAIL vector%0d got {V,C,S}=%h want %h", i, res, exp_res[i]);
            end
            n_checks++;
            if (lat !== 4) begin
                n_fail++; $display("FAIL latency%0d got %0d edges want 4", i, lat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        logic [WIDTH+1:0] res, exp_r;
        int lat, acc;
        bit bad;
        exp_r = ref_op(16'hABCD, 16'h1357, 1'b1, 1'b0);
        out_ready = 1'b0;
        run_op(16'hABCD, 16'h1357, 1'b1, 1'b0, res, lat, acc);
        n_checks++;
        if (res !== exp_r) begin
            n_fail++; $display("FAIL hold_result got %h want %h", res, exp_r);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({V, C_out, S} !== exp_r || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                dbg_state !== 2'(DONE)) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL hold_stable got %h ov=%b ir=%b want %h 1 0", {V, C_out, S}, out_valid, in_ready, exp_r);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_busy_ignore();
        logic [WIDTH+1:0] exp1, exp2;
        int n;
        exp1 = ref_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        exp2 = ref_op(16'h9000, 16'h0FFF, 1'b0, 1'b1);
        out_ready = 1'b0;
        A = 16'h1111; B = 16'h2222; C_in = 1'b0; SUB = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = 16'h9000; B = 16'h0FFF; SUB = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if ({V, C_out, S} !== exp1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL busy_first got %h ir=%b want %h 0", {V, C_out, S}, in_ready, exp1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if ({V, C_out, S} !== exp2 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL busy_second got %h ov=%b want %h 1", {V, C_out, S}, out_valid, exp2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH+1:0] res;
        int lat, acc;
        bit seen;
        out_ready = 1'b1;
        A = 16'hFFFF; B = 16'hFFFF; C_in = 1'b1; SUB = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({S, C_out, V, out_valid} !== 19'd0 || dbg_state !== 2'(IDLE) || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midrun_reset got S=%h C=%b V=%b ov=%b st=%0d want 0 IDLE", S, C_out, V, out_valid, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL midrun_discard got out_valid=1 want 0");
        end
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, res, lat, acc);
        n_checks++;
        if (res[WIDTH-1:0] !== 16'h2345) begin
            n_fail++; $display("FAIL after_reset_op got S=%h want 2345", res[WIDTH-1:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH+1:0] res, exp_r;
        logic [WIDTH-1:0] a, b;
        logic cin, sub;
        int lat, acc, prev_acc, bad_res, bad_gap;
        out_ready = 1'b1;
        bad_res = 0; bad_gap = 0; prev_acc = -1;
        for (int i = 0; i < 100; i++) begin
            case ($urandom_range(0, 4))
                0:       begin a = 16'hFFFF; b = WIDTH'($urandom); end
                1:       begin a = 16'h8000; b = 16'h7FFF; end
                default: begin a = WIDTH'($urandom); b = WIDTH'($urandom); end
            endcase
            cin = 1'($urandom); sub = 1'($urandom);
            exp_r = ref_op(a, b, cin, sub);
            run_op(a, b, cin, sub, res, lat, acc);
            if (res !== exp_r || lat !== 4) begin
                bad_res++;
                if (bad_res <= 3) $display("FAIL b2b_result op%0d got %h lat=%0d want %h lat=4", i, res, lat, exp_r);
            end
            if (prev_acc >= 0 && acc - prev_acc != 6) begin
                bad_gap++;
                if (bad_gap <= 3) $display("FAIL b2b_interval op%0d got %0d want 6", i, acc - prev_acc);
            end
            prev_acc = acc;
            @(negedge clk);
        end
        n_checks++;
        if (bad_res != 0) begin
            n_fail++; $display("FAIL b2b_results got %0d bad want 0", bad_res);
        end
        n_checks++;
        if (bad_gap != 0) begin
            n_fail++; $display("FAIL b2b_intervals got %0d bad want 0", bad_gap);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of DIGIT, minimum 4.
REQ-002 Parameter DIGIT, default 4, bits summed per clock cycle; 1 <= DIGIT <= WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 A  input  WIDTH  first operand.
REQ-008 B  input  WIDTH  second operand.
REQ-009 C_in  input  1  carry-in; ignored when SUB=1.
REQ-010 SUB  input  1  0 = A+B+C_in; 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 S  output  WIDTH  sum/difference.
REQ-014 C_out  output  1  carry out of bit WIDTH-1 (SUB=1: 1 = no borrow).
REQ-015 V  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 NDIG = WIDTH/DIGIT; the FSM SHALL have states IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; in_valid=1 SHALL latch A, (SUB ? ~B : B), and carry (SUB ? 1 : C_in), clear digit counter, and go to RUN.
REQ-018 RUN: in_ready=0, out_valid=0; each cycle SHALL add digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) of the latched operands plus the carry register, write S digit k, update the carry register, and increment k.
REQ-019 After digit NDIG-1 is processed, the FSM SHALL go to DONE with C_out and V registered from that final digit.
REQ-020 Latency: with acceptance at rising edge t, out_valid SHALL rise after edge t+NDIG (NDIG=4: after edge t+4).
REQ-021 DONE: out_valid=1, in_ready=0; S, C_out and V SHALL hold stable until out_ready=1.
REQ-022 DONE with out_ready=1 at an edge SHALL go to IDLE; the next acceptance occurs no earlier than the following edge (issue interval NDIG+2 cycles).
REQ-023 Changes on A, B, C_in and SUB outside the IDLE acceptance edge SHALL NOT affect the result.
REQ-024 in_valid with in_ready=0 SHALL be ignored; the source holds it until acceptance.
REQ-025 S digits not yet computed in RUN are undefined to the consumer; only out_valid qualifies outputs.
REQ-026 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-027 rst_n=0 SHALL, asynchronously and regardless of state (including mid-RUN), force state IDLE, S=0, C_out=0, V=0, out_valid=0, carry register=0, digit counter=0.
REQ-028 An in-flight operation interrupted by reset SHALL be discarded, never completed.
REQ-029 in_ready SHALL be 1 on the first edge after rst_n deasserts.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and a function computing NDIG and the counter width ($clog2(NDIG), minimum 1).
REQ-031 One combinational sub-module digit_add SHALL implement a DIGIT-bit ripple of full adders, with outputs sum, carry-out, and carry into its MSB (for V).
REQ-032 seq_adder SHALL instantiate exactly one digit_add, with operand digits selected by the counter.

Verification (WIDTH=16, DIGIT=4)
REQ-033 A=0xFFFF, B=0x0001, C_in=0, SUB=0 -> S=0x0000, C_out=1, V=0; out_valid after the 4th edge past acceptance.
REQ-034 A=0x7FFF, B=0x0001, C_in=0, SUB=0 -> S=0x8000, C_out=0, V=1.
REQ-035 A=0x0005, B=0x0007, SUB=1, C_in=1 -> S=0xFFFE, C_out=0, V=0 (C_in ignored).
REQ-036 out_ready=0 for 10 cycles in DONE -> S/C_out/V stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-037 rst_n pulsed low after 2 RUN cycles -> outputs 0, state IDLE immediately; new operation A=0x1234, B=0x1111 -> S=0x2345.
REQ-038 100 random back-to-back operations with out_ready=1 and random SUB/C_in -> every result matches the reference model; issue interval = 6 cycles.
